// File: rtl/cacheline_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the cacheline arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory model.
interface cacheline_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one memory cacheline port between the I-cache and D-cache miss paths.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise D always wins ties.
module cacheline_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input logic               clk,
  input logic               rst,
  cacheline_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e                state_q, state_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  last_d_q, last_d_d;  // 1: most recent completed grant was D

  logic d_req;
  logic i_req;
  logic grant_d;
  logic serving;

  assign d_req = bus.d_read | bus.d_write;
  assign i_req = bus.i_read;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~i_req | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_d_d   = last_d_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          // Read and write together is treated as a writeback.
          state_d    = StServeD;
          op_write_d = bus.d_write;
          addr_d     = bus.d_address;
          wdata_d    = bus.d_write ? bus.d_wdata : '0;
        end else if (i_req) begin
          state_d    = StServeI;
          op_write_d = 1'b0;
          addr_d     = bus.i_address;
          wdata_d    = '0;
        end
      end
      StServeI: begin
        if (bus.mem_resp) begin
          state_d  = StIdle;
          last_d_d = 1'b0;
        end
      end
      StServeD: begin
        if (bus.mem_resp) begin
          state_d  = StIdle;
          last_d_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_d_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_d_q   <= last_d_d;
    end
  end

  // Memory side is driven purely from registered state, so reset clears it at once.
  assign serving         = (state_q != StIdle);
  assign bus.mem_read    = serving & ~op_write_q;
  assign bus.mem_write   = serving & op_write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = op_write_q ? wdata_q : '0;

  assign bus.i_resp  = (state_q == StServeI) & bus.mem_resp;
  assign bus.d_resp  = (state_q == StServeD) & bus.mem_resp;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_cacheline_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cacheline_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned completed   = 0;
  bit          checking    = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & ~AW'(32'h1f);
  endfunction

  // Transaction-level model: is a line transfer outstanding, for whom, and what it is.
  logic          m_busy;
  logic          m_for_d;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic          m_last_d;

  function automatic logic model_picks_d(input logic i_want, input logic d_want,
                                         input logic last_was_d);
    if (!d_want) return 1'b0;
    if (!i_want) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    return !last_was_d;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_for_d  <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_last_d <= 1'b1;
    end else if (!m_busy) begin
      if (model_picks_d(bus.i_read, bus.d_read | bus.d_write, m_last_d)) begin
        m_busy  <= 1'b1;
        m_for_d <= 1'b1;
        m_write <= bus.d_write;
        m_addr  <= bus.d_address;
        m_wdata <= bus.d_wdata;
      end else if (bus.i_read) begin
        m_busy  <= 1'b1;
        m_for_d <= 1'b0;
        m_write <= 1'b0;
        m_addr  <= bus.i_address;
      end
    end else if (bus.mem_resp) begin
      m_busy   <= 1'b0;
      m_last_d <= m_for_d;
      completed <= completed + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("mem_read", LW'(bus.mem_read), LW'(m_busy && !m_write));
      check("mem_write", LW'(bus.mem_write), LW'(m_busy && m_write));
      if (m_busy) begin
        check("mem_address", LW'(bus.mem_address), LW'(m_addr));
        check("mem_wdata", bus.mem_wdata, m_write ? m_wdata : '0);
      end
      check("i_resp", LW'(bus.i_resp), LW'(m_busy && !m_for_d && bus.mem_resp));
      check("d_resp", LW'(bus.d_resp), LW'(m_busy && m_for_d && bus.mem_resp));
      check("i_rdata", bus.i_rdata, bus.mem_rdata);
      check("d_rdata", bus.d_rdata, bus.mem_rdata);
    end
  end

  logic i_seen, d_seen;
  always @(negedge clk) begin
    i_seen <= bus.i_resp;
    d_seen <= bus.d_resp;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_d_req();
    int unsigned k;
    k = $urandom_range(0, 5);
    bus.d_read    = (k <= 2) || (k == 5);
    bus.d_write   = (k >= 3);
    bus.d_address = rand_addr();
    bus.d_wdata   = rand_line();
  endtask

  logic [LW-1:0] line_a5;
  logic [LW-1:0] line_12;
  logic [AW-1:0] rr_addr[3];

  initial begin
    line_a5 = {32{8'ha5}};
    line_12 = {8{32'h1234_5678}};
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    cyc(); cyc();
    checking = 1'b1;
    @(negedge clk);
    check("reset_mem_read", LW'(bus.mem_read), '0);
    check("reset_mem_write", LW'(bus.mem_write), '0);
    check("reset_mem_address", LW'(bus.mem_address), '0);
    cyc();
    rst = 1'b0;
    cyc();

    // Lone I read.
    bus.i_read = 1'b1; bus.i_address = 32'h0000_0060;
    cyc();
    @(negedge clk);
    check("iread_mem_read", LW'(bus.mem_read), LW'(1));
    check("iread_mem_address", LW'(bus.mem_address), LW'(32'h60));
    cyc(); cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = line_a5;
    @(negedge clk);
    check("iread_i_resp", LW'(bus.i_resp), LW'(1));
    check("iread_i_rdata", bus.i_rdata, line_a5);
    check("iread_d_resp", LW'(bus.d_resp), '0);
    cyc();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);
    check("iread_idle", LW'(bus.mem_read), '0);
    cyc();

    // Lone D writeback, inputs disturbed once the transfer is latched.
    bus.d_write = 1'b1; bus.d_address = 32'h100; bus.d_wdata = line_12;
    cyc();
    bus.d_write = 1'b0; bus.d_address = 32'h200; bus.d_wdata = '0;
    @(negedge clk);
    check("dwr_mem_write", LW'(bus.mem_write), LW'(1));
    check("dwr_mem_read", LW'(bus.mem_read), '0);
    check("dwr_mem_address", LW'(bus.mem_address), LW'(32'h100));
    check("dwr_mem_wdata", bus.mem_wdata, line_12);
    cyc(); cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = '0;
    @(negedge clk);
    check("dwr_d_resp", LW'(bus.d_resp), LW'(1));
    cyc();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    check("dwr_d_resp_once", LW'(bus.d_resp), '0);
    check("dwr_idle", LW'(bus.mem_write), '0);

    // Both requesters held continuously.
`ifdef ARB_ROUND_ROBIN_EN
    rr_addr[0] = 32'h40; rr_addr[1] = 32'h80; rr_addr[2] = 32'h40;
`else
    rr_addr[0] = 32'h80; rr_addr[1] = 32'h80; rr_addr[2] = 32'h80;
`endif
    bus.i_read = 1'b1; bus.i_address = 32'h40;
    bus.d_read = 1'b1; bus.d_address = 32'h80;
    for (int t = 0; t < 3; t++) begin
      cyc();
      @(negedge clk);
      check("tie_grant_addr", LW'(bus.mem_address), LW'(rr_addr[t]));
      check("tie_mem_read", LW'(bus.mem_read), LW'(1));
      cyc();
      bus.mem_resp = 1'b1;
      cyc();
      bus.mem_resp = 1'b0;
      @(negedge clk);
      check("tie_turnaround", LW'(bus.mem_read), '0);
    end
    bus.d_read = 1'b0;
    cyc();
    @(negedge clk);
    check("tie_i_after_d_drop", LW'(bus.mem_address), LW'(32'h40));
    cyc();
    bus.mem_resp = 1'b1;
    cyc();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    cyc();

    // Reset in the middle of an I read, then a stray memory response.
    bus.i_read = 1'b1; bus.i_address = 32'h60;
    cyc();
    @(negedge clk);
    check("rst_pre_mem_read", LW'(bus.mem_read), LW'(1));
    cyc();
    rst = 1'b1;
    #1;
    check("rst_async_mem_read", LW'(bus.mem_read), '0);
    bus.i_read = 1'b0;
    cyc();
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check("rst_stray_i_resp", LW'(bus.i_resp), '0);
    check("rst_stray_d_resp", LW'(bus.d_resp), '0);
    cyc();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    check("rst_stays_idle", LW'(bus.mem_read | bus.mem_write), '0);
    cyc();

    // Randomized traffic, including protocol-violating input changes and resets.
    for (int n = 0; n < 4000; n++) begin
      bus.mem_resp  = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = rand_line();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (i_seen) begin
        bus.i_read = $urandom_range(0, 1);
        bus.i_address = rand_addr();
      end else if (!bus.i_read) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_read = 1'b1;
          bus.i_address = rand_addr();
        end
      end else if ($urandom_range(0, 19) == 0) begin
        bus.i_read = $urandom_range(0, 1);
        bus.i_address = rand_addr();
      end
      if (d_seen) begin
        if ($urandom_range(0, 1) == 0) rand_d_req();
        else begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      end else if (!(bus.d_read || bus.d_write)) begin
        if ($urandom_range(0, 2) == 0) rand_d_req();
      end else if ($urandom_range(0, 19) == 0) begin
        rand_d_req();
      end
      cyc();
    end
    bus.mem_resp = 1'b0;
    cyc();
    check("random_completions", LW'(completed > 100), LW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
